// File: rtl/ddr_burst_sched_pkg.sv
// Shared definitions for the DDR burst scheduler: scheduler state encoding
// and the width of the DDR controller burst-length field.
package ddr_burst_sched_pkg;

    localparam int BLEN_W = 10;

    typedef enum logic [2:0] {
        ST_INIT = 3'd0,
        ST_IDLE = 3'd1,
        ST_WR   = 3'd2,
        ST_RD   = 3'd3,
        ST_GAP  = 3'd4,
        ST_ERR  = 3'd5
    } sched_state_e;

endpackage

// File: rtl/ddr_sched_ring_ptr.sv
// Ring-buffer word offset. Advances by BURST_LEN on adv_i and wraps to 0
// when it reaches REGION_WORDS.
// Ports:
//   clk_i  - clock
//   rst_i  - synchronous active-high reset, clears the offset
//   adv_i  - advance by one burst
//   off_o  - current offset from the ring base
module ddr_sched_ring_ptr #(
    parameter int BURST_LEN    = 64,
    parameter int REGION_WORDS = 1 << 20,
    parameter int OFF_W        = 25
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             adv_i,
    output logic [OFF_W-1:0] off_o
);

    localparam int SUM_W = OFF_W + 1;

    logic [OFF_W-1:0] off_q, off_d;
    logic [SUM_W-1:0] sum;

    // One extra bit so a ring that spans the whole address space still
    // detects the wrap.
    always_comb begin
        sum   = {1'b0, off_q} + SUM_W'(BURST_LEN);
        off_d = off_q;
        if (adv_i) begin
            off_d = (sum >= SUM_W'(REGION_WORDS)) ? '0 : sum[OFF_W-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            off_q <= '0;
        end else begin
            off_q <= off_d;
        end
    end

    assign off_o = off_q;

endmodule

// File: rtl/ddr_burst_sched.sv
// Burst scheduler sharing the DDR burst interface between the AD FIFO
// (writes into the ring) and the wavelet FIFO (reads out of the ring).
// Fixed-length bursts, round-robin on ties, request held until finish.
// Optional finish watchdog: define DDR_BURST_SCHED_TIMEOUT_EN.
// Ports:
//   mem_clk, rst              - clock, synchronous active-high reset
//   local_init_done, enable   - calibration done, permit new bursts
//   ad_fifo_level             - words available in the AD FIFO
//   wav_fifo_level            - words used in the wavelet FIFO
//   wr_burst_* / rd_burst_*   - DDR controller burst request/finish
//   ddr_level                 - words stored in the ring
//   busy, timeout_err         - burst in flight, sticky watchdog flag
//   state_out                 - current state encoding
//
// state | meaning
// INIT  | waiting for DDR calibration
// IDLE  | sampling eligibility, arbitrating
// WR    | write burst requested, waiting for finish
// RD    | read burst requested, waiting for finish
// GAP   | one settle cycle for FIFO levels after a burst
// ERR   | watchdog expired, held until reset
module ddr_burst_sched
    import ddr_burst_sched_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 25,
    parameter int BURST_LEN      = 64,
    parameter int BASE_ADDR      = 0,
    parameter int REGION_WORDS   = 1 << 20,
    parameter int FIFO_LVL_W     = 10,
    parameter int WAV_FIFO_DEPTH = 512,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  mem_clk,
    input  logic                  rst,
    input  logic                  local_init_done,
    input  logic                  enable,
    input  logic [FIFO_LVL_W-1:0] ad_fifo_level,
    input  logic [FIFO_LVL_W-1:0] wav_fifo_level,
    output logic                  wr_burst_req,
    output logic [BLEN_W-1:0]     wr_burst_len,
    output logic [ADDR_WIDTH-1:0] wr_burst_addr,
    input  logic                  wr_burst_finish,
    output logic                  rd_burst_req,
    output logic [BLEN_W-1:0]     rd_burst_len,
    output logic [ADDR_WIDTH-1:0] rd_burst_addr,
    input  logic                  rd_burst_finish,
    output logic [ADDR_WIDTH:0]   ddr_level,
    output logic                  busy,
    output logic                  timeout_err,
    output logic [2:0]            state_out
);

    localparam int LVL_W = ADDR_WIDTH + 1;
    localparam logic [LVL_W-1:0]      LVL_BURST  = LVL_W'(BURST_LEN);
    localparam logic [LVL_W-1:0]      LVL_WR_MAX = LVL_W'(REGION_WORDS - BURST_LEN);
    localparam logic [FIFO_LVL_W-1:0] AD_MIN     = FIFO_LVL_W'(BURST_LEN);
    localparam logic [FIFO_LVL_W-1:0] WAV_MAX    = FIFO_LVL_W'(WAV_FIFO_DEPTH - BURST_LEN);
    localparam logic [ADDR_WIDTH-1:0] BASE       = ADDR_WIDTH'(BASE_ADDR);

    if (DATA_WIDTH < 1 || BURST_LEN < 1 || BURST_LEN > 1023 ||
        (REGION_WORDS % BURST_LEN) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("ddr_burst_sched: illegal parameter set");
    end

    sched_state_e          state_q, state_d;
    logic                  wr_req_q, wr_req_d, rd_req_q, rd_req_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic                  last_rd_q, last_rd_d;
    logic                  busy_q;
    logic                  wr_adv, rd_adv, wr_ok, rd_ok;
    logic [ADDR_WIDTH-1:0] wr_off, rd_off;

`ifdef DDR_BURST_SCHED_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;
`endif

    ddr_sched_ring_ptr #(
        .BURST_LEN(BURST_LEN), .REGION_WORDS(REGION_WORDS), .OFF_W(ADDR_WIDTH)
    ) u_wr_ptr (
        .clk_i(mem_clk), .rst_i(rst), .adv_i(wr_adv), .off_o(wr_off)
    );

    ddr_sched_ring_ptr #(
        .BURST_LEN(BURST_LEN), .REGION_WORDS(REGION_WORDS), .OFF_W(ADDR_WIDTH)
    ) u_rd_ptr (
        .clk_i(mem_clk), .rst_i(rst), .adv_i(rd_adv), .off_o(rd_off)
    );

    // Level bounds in the eligibility terms keep ddr_level inside [0, REGION_WORDS].
    assign wr_ok = (ad_fifo_level >= AD_MIN) && (level_q <= LVL_WR_MAX);
    assign rd_ok = (level_q >= LVL_BURST) && (wav_fifo_level <= WAV_MAX);

    always_comb begin
        state_d   = state_q;
        wr_req_d  = wr_req_q;
        rd_req_d  = rd_req_q;
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        level_d   = level_q;
        last_rd_d = last_rd_q;
        wr_adv    = 1'b0;
        rd_adv    = 1'b0;
`ifdef DDR_BURST_SCHED_TIMEOUT_EN
        tmo_d     = tmo_q;
        err_d     = err_q;
`endif
        case (state_q)
            ST_INIT: begin
                if (local_init_done) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                // On a tie the side that did not go last wins.
                if (enable && wr_ok && (!rd_ok || last_rd_q)) begin
                    state_d   = ST_WR;
                    wr_req_d  = 1'b1;
                    wr_addr_d = BASE + wr_off;
`ifdef DDR_BURST_SCHED_TIMEOUT_EN
                    tmo_d     = TMO_LOAD;
`endif
                end else if (enable && rd_ok) begin
                    state_d   = ST_RD;
                    rd_req_d  = 1'b1;
                    rd_addr_d = BASE + rd_off;
`ifdef DDR_BURST_SCHED_TIMEOUT_EN
                    tmo_d     = TMO_LOAD;
`endif
                end
            end
            ST_WR: begin
                if (wr_burst_finish) begin
                    wr_req_d  = 1'b0;
                    wr_adv    = 1'b1;
                    level_d   = level_q + LVL_BURST;
                    last_rd_d = 1'b0;
                    state_d   = ST_GAP;
                end
`ifdef DDR_BURST_SCHED_TIMEOUT_EN
                else if (tmo_q == '0) begin
                    wr_req_d = 1'b0;
                    err_d    = 1'b1;
                    state_d  = ST_ERR;
                end else begin
                    tmo_d = tmo_q - 1'b1;
                end
`endif
            end
            ST_RD: begin
                if (rd_burst_finish) begin
                    rd_req_d  = 1'b0;
                    rd_adv    = 1'b1;
                    level_d   = level_q - LVL_BURST;
                    last_rd_d = 1'b1;
                    state_d   = ST_GAP;
                end
`ifdef DDR_BURST_SCHED_TIMEOUT_EN
                else if (tmo_q == '0) begin
                    rd_req_d = 1'b0;
                    err_d    = 1'b1;
                    state_d  = ST_ERR;
                end else begin
                    tmo_d = tmo_q - 1'b1;
                end
`endif
            end
            ST_GAP:  state_d = ST_IDLE;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge mem_clk) begin
        if (rst) begin
            state_q   <= ST_INIT;
            wr_req_q  <= 1'b0;
            rd_req_q  <= 1'b0;
            wr_addr_q <= BASE;
            rd_addr_q <= BASE;
            level_q   <= '0;
            last_rd_q <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_req_q  <= wr_req_d;
            rd_req_q  <= rd_req_d;
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
            level_q   <= level_d;
            last_rd_q <= last_rd_d;
            busy_q    <= (state_d == ST_WR) || (state_d == ST_RD);
        end
    end

`ifdef DDR_BURST_SCHED_TIMEOUT_EN
    always_ff @(posedge mem_clk) begin
        if (rst) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end
    assign timeout_err = err_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign wr_burst_req  = wr_req_q;
    assign rd_burst_req  = rd_req_q;
    assign wr_burst_addr = wr_addr_q;
    assign rd_burst_addr = rd_addr_q;
    assign wr_burst_len  = BLEN_W'(BURST_LEN);
    assign rd_burst_len  = BLEN_W'(BURST_LEN);
    assign ddr_level     = level_q;
    assign busy          = busy_q;
    assign state_out     = state_q;

endmodule

// File: tb/tb_ddr_burst_sched.sv
`timescale 1ns/1ps
module tb_ddr_burst_sched;

    localparam int AW   = 25;
    localparam int BL   = 64;
    localparam int BASE = 32'h1000;
    localparam int RW   = 256;
    localparam int WAVD = 512;
    localparam int LW   = 10;
    localparam int TMO  = 16;

    logic          mem_clk = 1'b0;
    logic          rst, init_done, enable;
    logic [LW-1:0] ad_lvl, wav_lvl;
    logic          wr_req, rd_req, wr_fin, rd_fin;
    logic [9:0]    wr_len, rd_len;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [AW:0]   ddr_level;
    logic          busy, timeout_err;
    logic [2:0]    state_out;

    always #5 mem_clk = ~mem_clk;

    ddr_burst_sched #(
        .DATA_WIDTH(32), .ADDR_WIDTH(AW), .BURST_LEN(BL), .BASE_ADDR(BASE),
        .REGION_WORDS(RW), .FIFO_LVL_W(LW), .WAV_FIFO_DEPTH(WAVD), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .mem_clk(mem_clk), .rst(rst), .local_init_done(init_done), .enable(enable),
        .ad_fifo_level(ad_lvl), .wav_fifo_level(wav_lvl),
        .wr_burst_req(wr_req), .wr_burst_len(wr_len), .wr_burst_addr(wr_addr),
        .wr_burst_finish(wr_fin),
        .rd_burst_req(rd_req), .rd_burst_len(rd_len), .rd_burst_addr(rd_addr),
        .rd_burst_finish(rd_fin),
        .ddr_level(ddr_level), .busy(busy), .timeout_err(timeout_err), .state_out(state_out)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: ring occupancy, offsets and who went last.
    int m_level, m_wr_off, m_rd_off;
    bit m_last_rd;

    task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_level = 0; m_wr_off = 0; m_rd_off = 0; m_last_rd = 1'b1;
    endtask

    // 0 = no grant, 1 = write, 2 = read
    function automatic int predict();
        bit w_ok, r_ok;
        w_ok = (int'(ad_lvl) >= BL) && (m_level + BL <= RW);
        r_ok = (m_level >= BL) && (int'(wav_lvl) + BL <= WAVD);
        if (!enable || !(w_ok || r_ok)) return 0;
        if (w_ok && r_ok) return m_last_rd ? 1 : 2;
        return w_ok ? 1 : 2;
    endfunction

    task automatic tick();
        @(posedge mem_clk);
        #1;
    endtask

    task automatic rand_levels();
        ad_lvl  = ($urandom_range(0, 3) == 0) ? LW'($urandom_range(0, BL - 1))
                                              : LW'($urandom_range(BL - 1, 1023));
        wav_lvl = ($urandom_range(0, 3) == 0) ? LW'($urandom_range(WAVD - BL, 1023))
                                              : LW'($urandom_range(0, WAVD - BL + 1));
        enable  = ($urandom_range(0, 7) != 0);
    endtask

    // Called while the DUT sits in IDLE; checks the outcome of the next edge.
    task automatic expect_grant(output int g);
        g = predict();
        tick();
        chk_eq("wr_req", wr_req, g == 1);
        chk_eq("rd_req", rd_req, g == 2);
        chk_eq("busy", busy, g != 0);
        if (g == 1) begin
            chk_eq("wr_addr", wr_addr, BASE + m_wr_off);
            chk_eq("wr_len", wr_len, BL);
        end else if (g == 2) begin
            chk_eq("rd_addr", rd_addr, BASE + m_rd_off);
            chk_eq("rd_len", rd_len, BL);
        end else begin
            chk_eq("idle_state", state_out, 1);
        end
    endtask

    // Holds the granted burst a few cycles, finishes it, then checks GAP/IDLE
    // timing and the next arbitration outcome.
    task automatic service(input int g, input bit rand_next, output int gn);
        int hold;
        hold = $urandom_range(0, 4);
        for (int i = 0; i < hold; i++) begin
            if (g == 1) rd_fin = 1'($urandom_range(0, 1));
            else        wr_fin = 1'($urandom_range(0, 1));
            if (rand_next) rand_levels();
            tick();
            wr_fin = 1'b0; rd_fin = 1'b0;
            chk_eq("hold_req", (g == 1) ? wr_req : rd_req, 1);
            chk_eq("hold_addr", (g == 1) ? wr_addr : rd_addr,
                   BASE + ((g == 1) ? m_wr_off : m_rd_off));
            chk_eq("hold_state", state_out, (g == 1) ? 2 : 3);
            chk_eq("hold_level", ddr_level, m_level);
        end
        if (g == 1) wr_fin = 1'b1; else rd_fin = 1'b1;
        tick();
        wr_fin = 1'b0; rd_fin = 1'b0;
        if (g == 1) begin
            m_level += BL; m_wr_off = (m_wr_off + BL) % RW; m_last_rd = 1'b0;
        end else begin
            m_level -= BL; m_rd_off = (m_rd_off + BL) % RW; m_last_rd = 1'b1;
        end
        chk_eq("fin_wr_req", wr_req, 0);
        chk_eq("fin_rd_req", rd_req, 0);
        chk_eq("fin_level", ddr_level, m_level);
        chk_eq("fin_state_gap", state_out, 4);
        chk_eq("fin_busy", busy, 0);
        if (rand_next) rand_levels();
        tick();
        chk_eq("gap_idle_state", state_out, 1);
        chk_eq("gap_no_req", wr_req | rd_req, 0);
        expect_grant(gn);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int g;
        rst = 1'b1; init_done = 1'b0; enable = 1'b1;
        ad_lvl = 10'd200; wav_lvl = 10'd0; wr_fin = 1'b0; rd_fin = 1'b0;
        model_reset();
        repeat (3) tick();
        chk_eq("rst_wr_req", wr_req, 0);
        chk_eq("rst_rd_req", rd_req, 0);
        chk_eq("rst_wr_addr", wr_addr, BASE);
        chk_eq("rst_rd_addr", rd_addr, BASE);
        chk_eq("rst_wr_len", wr_len, BL);
        chk_eq("rst_rd_len", rd_len, BL);
        chk_eq("rst_level", ddr_level, 0);
        chk_eq("rst_busy", busy, 0);
        chk_eq("rst_tmo_err", timeout_err, 0);
        chk_eq("rst_state", state_out, 0);
        rst = 1'b0;

        // Init gating
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_eq("init_gate_req", wr_req, 0);
            chk_eq("init_gate_state", state_out, 0);
        end
        init_done = 1'b1;
        tick();
        chk_eq("init_idle_state", state_out, 1);
        chk_eq("init_idle_req", wr_req, 0);
        expect_grant(g);

        // Fill/drain and round-robin with both sides permanently willing
        ad_lvl = 10'd1023; wav_lvl = 10'd0;
        for (int k = 0; k < 7 && g != 0; k++) service(g, 1'b0, g);

        // Fill the ring to the top with reads blocked
        wav_lvl = 10'd500;
        for (int k = 0; k < 10 && g != 0; k++) service(g, 1'b0, g);
        chk_eq("full_level", ddr_level, RW);
        expect_grant(g);
        wav_lvl = 10'd0;
        expect_grant(g);
        for (int k = 0; k < 3 && g != 0; k++) service(g, 1'b0, g);

        // Randomized traffic
        for (int it = 0; it < 300; it++) begin
            if (g != 0) service(g, 1'b1, g);
            else begin
                rand_levels();
                expect_grant(g);
            end
        end

        // Reset (possibly mid-burst) clears requests, level and offsets
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        chk_eq("mid_rst_wr_req", wr_req, 0);
        chk_eq("mid_rst_rd_req", rd_req, 0);
        chk_eq("mid_rst_level", ddr_level, 0);
        chk_eq("mid_rst_state", state_out, 0);
        enable = 1'b1; ad_lvl = 10'd200; wav_lvl = 10'd449;
        tick();
        chk_eq("post_rst_idle", state_out, 1);
        expect_grant(g);

        // Back-pressure on the wavelet side at the 448/449 boundary
        ad_lvl = 10'd0;
        service(g, 1'b0, g);
        chk_eq("bp_level", ddr_level, 64);
        for (int i = 0; i < 3; i++) expect_grant(g);
        wav_lvl = 10'd448;
        expect_grant(g);
        chk_eq("bp_rd_req", rd_req, 1);
        service(g, 1'b0, g);

        ad_lvl = 10'd200;
        if (g == 0) expect_grant(g);
`ifdef DDR_BURST_SCHED_TIMEOUT_EN
        for (int i = 1; i < TMO; i++) begin
            tick();
            chk_eq("tmo_hold_req", wr_req, 1);
        end
        tick();
        chk_eq("tmo_req_drop", wr_req, 0);
        chk_eq("tmo_err", timeout_err, 1);
        chk_eq("tmo_state", state_out, 5);
        chk_eq("tmo_busy", busy, 0);
        wr_fin = 1'b1;
        tick();
        wr_fin = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_eq("err_hold_state", state_out, 5);
            chk_eq("err_hold_level", ddr_level, m_level);
            chk_eq("err_hold_flag", timeout_err, 1);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_eq("err_rst_state", state_out, 0);
        chk_eq("err_rst_flag", timeout_err, 0);
`else
        for (int i = 0; i < 40; i++) begin
            tick();
            chk_eq("no_tmo_hold_req", wr_req, 1);
            chk_eq("no_tmo_err", timeout_err, 0);
        end
        if (g != 0) service(g, 1'b0, g);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
